// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router and its packet source: transmit
// states, header field layout and legality checks for address and length.
package router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } tx_state_e;

  localparam int ADDR_LSB  = 0;
  localparam int LEN_LSB   = 2;
  localparam int MAX_LEN   = 63;
  localparam int NUM_PORTS = 3;

  function automatic logic addr_legal(input int addr);
    return (addr >= 0) && (addr < NUM_PORTS);
  endfunction

  function automatic logic len_legal(input int len);
    return (len >= 1) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for the packet source: one write port, combinational read.
module router_tx_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; every byte read was written this packet.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a payload, then sends header, payload and
// parity back-to-back, holding each word while the router asserts busy.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            dest_addr,
  input  logic [LEN_WIDTH-1:0]  pay_len,
  input  logic [DATA_WIDTH-1:0] pay_data,
  input  logic                  pay_valid,
  output logic                  pay_ready,
  input  logic                  busy,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  packet_valid,
  output logic                  idle,
  output logic                  done,
  output logic                  err
);

  tx_state_e             state_q, state_d;
  logic [1:0]            addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEN_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] parity_q, parity_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  packet_valid_q, packet_valid_d;
  logic                  pay_ready_q, pay_ready_d;
  logic                  idle_q, idle_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  buf_we;
  logic                  start_legal;
  logic                  last_load;
  logic                  consume;

  function automatic logic [DATA_WIDTH-1:0] make_header(input logic [1:0] a,
                                                        input logic [LEN_WIDTH-1:0] l);
    logic [DATA_WIDTH-1:0] h;
    h = '0;
    h[ADDR_LSB +: 2]       = a;
    h[LEN_LSB +: LEN_WIDTH] = l;
    return h;
  endfunction

  assign buf_we      = (state_q == S_LOAD) && pay_valid;
  assign start_legal = addr_legal(int'(dest_addr)) && len_legal(int'(pay_len));
  assign last_load   = (wr_ptr_q == len_q - LEN_WIDTH'(1));
  assign consume     = !busy;

  router_tx_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(LEN_WIDTH)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(wr_ptr_q),
    .wdata(pay_data),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  // rd_ptr always points at the next byte to put on the bus, so it equals
  // len_q while the last payload byte is being offered.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    parity_d       = parity_q;
    data_in_d      = data_in_q;
    packet_valid_d = packet_valid_q;
    pay_ready_d    = pay_ready_q;
    idle_d         = idle_q;
    done_d         = 1'b0;
    err_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_legal) begin
            addr_d      = dest_addr;
            len_d       = pay_len;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            parity_d    = make_header(dest_addr, pay_len);
            pay_ready_d = 1'b1;
            idle_d      = 1'b0;
            state_d     = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (pay_valid) begin
          wr_ptr_d = wr_ptr_q + LEN_WIDTH'(1);
          parity_d = parity_q ^ pay_data;
          if (last_load) begin
            data_in_d      = make_header(addr_q, len_q);
            packet_valid_d = 1'b1;
            pay_ready_d    = 1'b0;
            state_d        = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (consume) begin
          data_in_d = rd_data;
          rd_ptr_d  = rd_ptr_q + LEN_WIDTH'(1);
          state_d   = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (consume) begin
          if (rd_ptr_q == len_q) begin
            data_in_d      = parity_q;
            packet_valid_d = 1'b0;
            state_d        = S_PARITY;
          end else begin
            data_in_d = rd_data;
            rd_ptr_d  = rd_ptr_q + LEN_WIDTH'(1);
          end
        end
      end
      S_PARITY: begin
        if (consume) begin
          data_in_d = '0;
          done_d    = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        idle_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      parity_q       <= '0;
      data_in_q      <= '0;
      packet_valid_q <= 1'b0;
      pay_ready_q    <= 1'b0;
      idle_q         <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      parity_q       <= parity_d;
      data_in_q      <= data_in_d;
      packet_valid_q <= packet_valid_d;
      pay_ready_q    <= pay_ready_d;
      idle_q         <= idle_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign data_in      = data_in_q;
  assign packet_valid = packet_valid_q;
  assign pay_ready    = pay_ready_q;
  assign idle         = idle_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: per-cycle vector table plus scoreboarded
// sequences for mid-packet reset and a maximum-length packet under random busy.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pay_len;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic [7:0] data_in;
  logic       packet_valid;
  logic       idle;
  logic       done;
  logic       err;

  int total_cnt  = 0;
  int passed_cnt = 0;

  logic [7:0] pay [64];

  typedef struct {
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       pv;
    logic [7:0] pd;
    logic       busy;
    logic [7:0] e_data;
    logic       e_pktv;
    logic       e_ready;
    logic       e_idle;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  router_pkt_tx #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dest_addr   (dest_addr),
    .pay_len     (pay_len),
    .pay_data    (pay_data),
    .pay_valid   (pay_valid),
    .pay_ready   (pay_ready),
    .busy        (busy),
    .data_in     (data_in),
    .packet_valid(packet_valid),
    .idle        (idle),
    .done        (done),
    .err         (err)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want normal end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) passed_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] a, input logic [5:0] l,
                              input logic pv, input logic [7:0] pd, input logic b,
                              input logic [7:0] ed, input logic epk, input logic er,
                              input logic ei, input logic edn, input logic ee);
    vec_t v;
    v.start = st; v.addr = a; v.len = l; v.pv = pv; v.pd = pd; v.busy = b;
    v.e_data = ed; v.e_pktv = epk; v.e_ready = er; v.e_idle = ei; v.e_done = edn; v.e_err = ee;
    return v;
  endfunction

  function automatic logic [12:0] pack_out();
    return {data_in, packet_valid, pay_ready, idle, done, err};
  endfunction

  task automatic drive_idle_inputs();
    start = 0; dest_addr = 0; pay_len = 0; pay_data = 0; pay_valid = 0; busy = 0;
  endtask

  task automatic fill_table();
    // Normal: addr 1, len 3. Header {3,1}=0x0D; 0x11^0x22^0x33 cancels, so parity is 0x0D.
    vecs.push_back(mk(1,1,3, 0,8'h00,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'h11,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'h22,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'h33,0, 8'h0D,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h11,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h22,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h33,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h0D,0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h00,0,0,0,1,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h00,0,0,1,0,0));
    // Back-pressure: busy 2 on header, 3 on second payload byte, 1 on parity.
    vecs.push_back(mk(1,1,3, 0,8'h00,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'h11,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'h22,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'h33,0, 8'h0D,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,1, 8'h0D,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,1, 8'h0D,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h11,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h22,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,1, 8'h22,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,1, 8'h22,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,1, 8'h22,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h33,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h0D,0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,1, 8'h0D,0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h00,0,0,0,1,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h00,0,0,1,0,0));
    // Load stalls: addr 0, len 4, header 0x10, parity 0x10^A1^B2^C3^D4 = 0x14.
    vecs.push_back(mk(1,0,4, 0,8'h00,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'hA1,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'hEE,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'hEE,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'hB2,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'hC3,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'hEE,0, 8'h00,0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 1,8'hD4,0, 8'h10,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'hA1,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'hB2,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'hC3,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'hD4,1,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h14,0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h00,0,0,0,1,0));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h00,0,0,1,0,0));
    // Rejects: illegal address, then zero length.
    vecs.push_back(mk(1,3,3, 0,8'h00,0, 8'h00,0,0,1,0,1));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h00,0,0,1,0,0));
    vecs.push_back(mk(1,0,0, 0,8'h00,0, 8'h00,0,0,1,0,1));
    vecs.push_back(mk(0,0,0, 0,8'h00,0, 8'h00,0,0,1,0,0));
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; dest_addr = vecs[i].addr; pay_len = vecs[i].len;
      pay_valid = vecs[i].pv; pay_data = vecs[i].pd; busy = vecs[i].busy;
      tick();
      check($sformatf("vec%0d {data,pktv,ready,idle,done,err}", i), 32'(pack_out()),
            32'({vecs[i].e_data, vecs[i].e_pktv, vecs[i].e_ready,
                 vecs[i].e_idle, vecs[i].e_done, vecs[i].e_err}));
    end
    drive_idle_inputs();
  endtask

  // Loads pay[0..len-1], then records every word consumed (busy low at the edge).
  task automatic send_packet(input string name, input logic [1:0] a, input int len,
                             input int busy_pct);
    logic [7:0] words[$];
    logic       flags[$];
    logic [7:0] exp_par;
    logic [7:0] pre_data;
    logic       pre_pv;
    logic       b;
    int         hold_err = 0;
    int         pv_err = 0;

    start = 1; dest_addr = a; pay_len = 6'(len);
    tick();
    start = 0; dest_addr = 0; pay_len = 0;
    for (int i = 0; i < len; i++) begin
      pay_valid = 1; pay_data = pay[i];
      tick();
    end
    pay_valid = 0; pay_data = 0;
    for (int cyc = 0; cyc < 8 * len + 50; cyc++) begin
      b = ($urandom_range(99) < busy_pct);
      busy = b;
      pre_data = data_in;
      pre_pv = packet_valid;
      tick();
      if (b) begin
        if (data_in !== pre_data || packet_valid !== pre_pv) hold_err++;
      end else if (pre_pv || words.size() > 0) begin
        words.push_back(pre_data);
        flags.push_back(pre_pv);
        if (words.size() == len + 2) break;
      end
    end
    busy = 0;
    check({name, " word count"}, 32'(words.size()), 32'(len + 2));
    check({name, " done pulse"}, 32'(done), 32'd1);
    tick();
    check({name, " idle after done"}, 32'({idle, done}), 32'b10);

    exp_par = {6'(len), a};
    if (words.size() > 0) check({name, " header"}, 32'(words[0]), 32'(exp_par));
    for (int i = 0; i < len; i++) begin
      exp_par ^= pay[i];
      if (i + 1 < words.size())
        check($sformatf("%s payload[%0d]", name, i), 32'(words[i + 1]), 32'(pay[i]));
    end
    if (words.size() == len + 2) check({name, " parity"}, 32'(words[len + 1]), 32'(exp_par));
    for (int i = 0; i < flags.size(); i++) begin
      if (flags[i] !== (i <= len)) pv_err++;
    end
    check({name, " packet_valid pattern errors"}, 32'(pv_err), 32'd0);
    check({name, " hold violations under busy"}, 32'(hold_err), 32'd0);
  endtask

  initial begin
    int done_seen;
    reset = 1;
    drive_idle_inputs();
    tick();
    tick();
    check("reset outputs {data,pktv,ready,idle,done,err}", 32'(pack_out()), 32'h0004);
    reset = 0;
    tick();

    fill_table();
    run_table();

    // Reset after two of five payload bytes have been consumed.
    start = 1; dest_addr = 0; pay_len = 5;
    tick();
    start = 0; pay_len = 0;
    for (int i = 0; i < 5; i++) begin
      pay_valid = 1; pay_data = 8'(i + 1);
      tick();
    end
    pay_valid = 0; pay_data = 0;
    tick();
    tick();
    tick();
    check("midreset third byte on bus", 32'({data_in, packet_valid}), 32'({8'h03, 1'b1}));
    reset = 1;
    tick();
    reset = 0;
    check("midreset outputs {data,pktv,ready,idle,done,err}", 32'(pack_out()), 32'h0004);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || packet_valid) done_seen++;
    end
    check("midreset no done/packet_valid afterwards", 32'(done_seen), 32'd0);

    pay[0] = 8'h5A;
    send_packet("post-reset addr2 len1", 2'd2, 1, 0);

    for (int i = 0; i < 63; i++) pay[i] = 8'($urandom_range(255));
    send_packet("max addr2 len63", 2'd2, 63, 40);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
